// File: rtl/ring_phase_monitor.sv
// Monitors a one-hot ring counter: decodes the phase, checks legality and rotation order,
// counts completed rotations and reports lock and sticky fault status.
module ring_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int CNT_W    = 8,
    parameter int LOCK_ROT = 2
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic                     phase_valid,
    output logic                     rot_tick,
    output logic [CNT_W-1:0]         rot_count,
    output logic                     locked,
    output logic                     err_onehot,
    output logic                     err_seq
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int LCK_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] to_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [WIDTH-1:0] rotate_up(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [CNT_W-1:0]  rot_cnt_q, rot_cnt_d;
    logic [LCK_W-1:0]  clean_q, clean_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pvalid_q, pvalid_d;
    logic              tick_q, tick_d;
    logic              locked_q;
    logic              err_oh_q, err_oh_d;
    logic              err_sq_q, err_sq_d;

    logic              samp_zero, samp_onehot, samp_bad;
    logic              prev_onehot, trans_bad, wrap, rot_hit, lock_reached;
    logic [LCK_W-1:0]  clean_next;

    // Sample classification and transition legality against the previous enabled sample
    assign samp_zero    = (ring_in == '0);
    assign samp_onehot  = is_onehot(ring_in);
    assign samp_bad     = !samp_zero && !samp_onehot;
    assign prev_onehot  = is_onehot(prev_q);
    assign trans_bad    = prev_onehot && samp_onehot &&
                          (ring_in != prev_q) && (ring_in != rotate_up(prev_q));
    assign wrap         = prev_onehot && samp_onehot && prev_q[WIDTH-1] && ring_in[0];
    assign rot_hit      = wrap && ((state_q == S_ACQUIRE) || (state_q == S_LOCKED));
    assign clean_next   = clean_q + LCK_W'(1);
    assign lock_reached = (clean_next == LCK_W'(LOCK_ROT));

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        rot_cnt_d = rot_cnt_q;
        clean_d   = clean_q;
        idx_d     = idx_q;
        pvalid_d  = 1'b0;
        tick_d    = 1'b0;
        err_oh_d  = err_oh_q;
        err_sq_d  = err_sq_q;

        if (!en) begin
            state_d   = S_IDLE;
            prev_d    = '0;
            rot_cnt_d = '0;
            clean_d   = '0;
        end else begin
            prev_d   = ring_in;
            pvalid_d = samp_onehot;
            tick_d   = rot_hit;
            if (samp_onehot) idx_d = to_index(ring_in);
            // A new error on the same edge as err_clr keeps the flag set
            err_oh_d = (err_oh_q & ~err_clr) | samp_bad;
            err_sq_d = (err_sq_q & ~err_clr) | trans_bad;

            if (samp_zero) begin
                state_d   = S_IDLE;
                rot_cnt_d = '0;
                clean_d   = '0;
            end else if (samp_bad || trans_bad) begin
                clean_d = '0;
                if (state_q == S_ACQUIRE)     state_d = S_IDLE;
                else if (state_q == S_LOCKED) state_d = S_FAULT;
            end else begin
                if (rot_hit) rot_cnt_d = rot_cnt_q + CNT_W'(1);
                case (state_q)
                    S_IDLE: begin
                        state_d = S_ACQUIRE;
                        clean_d = '0;
                    end
                    S_ACQUIRE: begin
                        if (rot_hit) begin
                            if (lock_reached) begin
                                state_d = S_LOCKED;
                                clean_d = '0;
                            end else begin
                                clean_d = clean_next;
                            end
                        end
                    end
                    S_LOCKED: state_d = S_LOCKED;
                    S_FAULT: begin
                        if (err_clr) state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= S_IDLE;
            prev_q    <= '0;
            rot_cnt_q <= '0;
            clean_q   <= '0;
            idx_q     <= '0;
            pvalid_q  <= 1'b0;
            tick_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_oh_q  <= 1'b0;
            err_sq_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            rot_cnt_q <= rot_cnt_d;
            clean_q   <= clean_d;
            idx_q     <= idx_d;
            pvalid_q  <= pvalid_d;
            tick_q    <= tick_d;
            locked_q  <= (state_d == S_LOCKED);
            err_oh_q  <= err_oh_d;
            err_sq_q  <= err_sq_d;
        end
    end

    assign phase_idx   = idx_q;
    assign phase_valid = pvalid_q;
    assign rot_tick    = tick_q;
    assign rot_count   = rot_cnt_q;
    assign locked      = locked_q;
    assign err_onehot  = err_oh_q;
    assign err_seq     = err_sq_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed and randomized checks of ring_phase_monitor against an index-arithmetic reference model.
module tb_ring_phase_monitor;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam int LR = 2;

    localparam int M_IDLE    = 0;
    localparam int M_ACQUIRE = 1;
    localparam int M_LOCKED  = 2;
    localparam int M_FAULT   = 3;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          en;
    logic          err_clr;
    logic [W-1:0]  ring_in;
    logic [1:0]    phase_idx;
    logic          phase_valid;
    logic          rot_tick;
    logic [CW-1:0] rot_count;
    logic          locked;
    logic          err_onehot;
    logic          err_seq;

    int checks = 0;
    int errors = 0;

    int           m_mode, m_rot, m_clean, m_idx;
    logic [W-1:0] m_prev;
    bit           m_pv, m_tick, m_eo, m_es;

    int           pos;
    logic [W-1:0] last_ring;

    ring_phase_monitor #(.WIDTH(W), .CNT_W(CW), .LOCK_ROT(LR)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .en         (en),
        .ring_in    (ring_in),
        .err_clr    (err_clr),
        .phase_idx  (phase_idx),
        .phase_valid(phase_valid),
        .rot_tick   (rot_tick),
        .rot_count  (rot_count),
        .locked     (locked),
        .err_onehot (err_onehot),
        .err_seq    (err_seq)
    );

    always #5 clk = ~clk;

    function automatic int bit_pos(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_rot = 0; m_clean = 0; m_idx = 0;
        m_prev = '0; m_pv = 0; m_tick = 0; m_eo = 0; m_es = 0;
    endtask

    task automatic model_step(input logic e, input logic [W-1:0] r, input logic c);
        int  n_cur, n_prev, ci, pi;
        bit  oh, bad, illegal, wrapped;
        if (!e) begin
            m_mode = M_IDLE; m_prev = '0; m_rot = 0; m_clean = 0; m_pv = 0; m_tick = 0;
            return;
        end
        n_cur  = $countones(r);
        n_prev = $countones(m_prev);
        ci     = bit_pos(r);
        pi     = bit_pos(m_prev);
        oh     = (n_cur == 1);
        bad    = (n_cur > 1);
        illegal = oh && (n_prev == 1) && !((ci == pi) || (ci == (pi + 1) % W));
        wrapped = oh && (n_prev == 1) && (pi == W - 1) && (ci == 0) &&
                  (m_mode == M_ACQUIRE || m_mode == M_LOCKED);
        m_pv   = oh;
        m_tick = wrapped;
        if (oh) m_idx = ci;
        m_eo = (m_eo && !c) || bad;
        m_es = (m_es && !c) || illegal;
        if (n_cur == 0) begin
            m_mode = M_IDLE; m_rot = 0; m_clean = 0;
        end else if (bad || illegal) begin
            m_clean = 0;
            if (m_mode == M_ACQUIRE)     m_mode = M_IDLE;
            else if (m_mode == M_LOCKED) m_mode = M_FAULT;
        end else begin
            if (wrapped) m_rot = (m_rot + 1) % (1 << CW);
            if (m_mode == M_IDLE) begin
                m_mode = M_ACQUIRE; m_clean = 0;
            end else if (m_mode == M_ACQUIRE && wrapped) begin
                m_clean++;
                if (m_clean == LR) begin
                    m_mode = M_LOCKED; m_clean = 0;
                end
            end else if (m_mode == M_FAULT && c) begin
                m_mode = M_IDLE;
            end
        end
        m_prev = r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("phase_idx",   32'(phase_idx),   32'(m_idx));
        chk("phase_valid", 32'(phase_valid), 32'(m_pv));
        chk("rot_tick",    32'(rot_tick),    32'(m_tick));
        chk("rot_count",   32'(rot_count),   32'(m_rot));
        chk("locked",      32'(locked),      32'(m_mode == M_LOCKED));
        chk("err_onehot",  32'(err_onehot),  32'(m_eo));
        chk("err_seq",     32'(err_seq),     32'(m_es));
    endtask

    task automatic step(input logic e, input logic [W-1:0] r, input logic c);
        @(negedge clk);
        en = e; ring_in = r; err_clr = c; last_ring = r;
        @(posedge clk);
        model_step(e, r, c);
        #1;
        check_all();
    endtask

    task automatic run_ring(input int n);
        logic [W-1:0] v;
        repeat (n) begin
            v = '0;
            v[pos] = 1'b1;
            step(1'b1, v, 1'b0);
            pos = (pos + 1) % W;
        end
    endtask

    task automatic pulse_reset();
        #1;
        clear_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_async_locked", 32'(locked), 32'd0);
        chk("rst_async_count",  32'(rot_count), 32'd0);
        #1;
        clear_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] v;
        int           r;
        clear_n = 1'b0; en = 1'b0; err_clr = 1'b0; ring_in = '0; last_ring = '0; pos = 0;
        model_reset();
        #1;
        check_all();
        #2;
        clear_n = 1'b1;

        // clean lock
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        pos = 0;
        run_ring(5);
        chk("first_tick", 32'(rot_tick), 32'd1);
        chk("not_locked_yet", 32'(locked), 32'd0);
        run_ring(4);
        chk("lock_tick", 32'(rot_tick), 32'd1);
        chk("lock_rise", 32'(locked), 32'd1);
        chk("lock_count", 32'(rot_count), 32'd2);

        // asynchronous reset while locked
        pulse_reset();
        step(1'b1, 4'b0000, 1'b0);
        pos = 0;
        run_ring(9);
        chk("relock", 32'(locked), 32'd1);

        // non-one-hot sample while locked
        step(1'b1, 4'b0011, 1'b0);
        chk("bad_err_onehot", 32'(err_onehot), 32'd1);
        chk("bad_pvalid", 32'(phase_valid), 32'd0);
        chk("bad_unlock", 32'(locked), 32'd0);
        step(1'b1, 4'b0000, 1'b0);
        chk("zero_count", 32'(rot_count), 32'd0);
        pos = 0;
        run_ring(9);
        chk("sticky_onehot", 32'(err_onehot), 32'd1);

        // skipped phase while locked, then clear and hold check
        step(1'b1, 4'b0100, 1'b0);
        chk("skip_err_seq", 32'(err_seq), 32'd1);
        chk("skip_unlock", 32'(locked), 32'd0);
        step(1'b1, 4'b0100, 1'b1);
        chk("clr_err_seq", 32'(err_seq), 32'd0);
        chk("clr_err_onehot", 32'(err_onehot), 32'd0);
        pos = 3;
        run_ring(9);
        run_ring(3);
        step(1'b1, 4'b0100, 1'b0);
        chk("hold_no_err", 32'(err_seq), 32'd0);
        chk("hold_locked", 32'(locked), 32'd1);

        // clear and set on the same edge
        step(1'b1, 4'b0101, 1'b1);
        chk("set_wins", 32'(err_onehot), 32'd1);
        step(1'b1, 4'b0100, 1'b1);
        chk("later_clear", 32'(err_onehot), 32'd0);

        // enable gap mid-sequence
        pos = 3;
        run_ring(9);
        run_ring(2);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        chk("gap_unlock", 32'(locked), 32'd0);
        chk("gap_count", 32'(rot_count), 32'd0);
        step(1'b1, 4'b0100, 1'b0);
        chk("reen_no_seq", 32'(err_seq), 32'd0);
        chk("reen_idx", 32'(phase_idx), 32'd2);
        pos = 3;
        run_ring(6);

        // rotation counter wraps silently
        step(1'b1, 4'b0000, 1'b0);
        pos = 0;
        run_ring(1 + 4 * 257);
        chk("cnt_wrap", 32'(rot_count), 32'd1);
        chk("cnt_wrap_flags", 32'({err_onehot, err_seq}), 32'd0);

        // randomized traffic around a rotating ring
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            v = last_ring;
            if (r < 70) begin
                v = '0; v[pos] = 1'b1; pos = (pos + 1) % W;
            end else if (r < 80) begin
                v = last_ring;
            end else if (r < 85) begin
                v = '0;
            end else if (r < 92) begin
                v = W'($urandom_range(0, 15));
            end else begin
                pos = (pos + 2) % W;
                v = '0; v[pos] = 1'b1;
            end
            step(($urandom_range(0, 19) != 0), v, ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
